// File: rtl/dmem_responder.sv
// Byte-addressable little-endian data memory behind valid/ready request/response channels.
// Optional statistics counters (stat_rd/stat_wr/stat_err) are enabled by defining DMEM_STATS_EN.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
`ifdef DMEM_STATS_EN
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
  output logic [31:0] stat_err,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // once raised, rsp_valid and rsp_rdata/rsp_err hold until that transfer completes.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;
  logic [3:0]  cnt_q;

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  logic accept;
  logic access;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign access    = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign req_ready = rst_n && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid)      state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0)  state_d = S_RESP;
      S_RESP:  if (rsp_ready)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 3'd0;
      cnt_q   <= 4'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      cnt_q   <= 4'(LATENCY);
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Access legality: size encoding, natural alignment and the last touched byte in range.
  logic [2:0]  nbytes;
  logic        size_ok;
  logic        misaligned;
  logic [32:0] last_addr;
  logic        acc_err;

  always_comb begin
    nbytes  = 3'd0;
    size_ok = 1'b0;
    case (size_q)
      3'b000: begin nbytes = 3'd1; size_ok = 1'b1;  end
      3'b001: begin nbytes = 3'd2; size_ok = 1'b1;  end
      3'b010: begin nbytes = 3'd4; size_ok = 1'b1;  end
      3'b100: begin nbytes = 3'd1; size_ok = !we_q; end
      3'b101: begin nbytes = 3'd2; size_ok = !we_q; end
      default: begin nbytes = 3'd0; size_ok = 1'b0; end
    endcase
  end

  assign misaligned = ((nbytes == 3'd2) && addr_q[0]) ||
                      ((nbytes == 3'd4) && (addr_q[1:0] != 2'b00));
  assign last_addr  = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
  assign acc_err    = !size_ok || misaligned || (last_addr >= 33'(DEPTH_BYTES));

  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_data;

  assign idx0 = addr_q[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  always_comb begin
    load_data = 32'd0;
    case (size_q)
      3'b000:  load_data = {{24{b0[7]}}, b0};
      3'b001:  load_data = {{16{b1[7]}}, b1, b0};
      3'b010:  load_data = {b3, b2, b1, b0};
      3'b100:  load_data = {24'd0, b0};
      3'b101:  load_data = {16'd0, b1, b0};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_data;
    end
  end

  // RAM is never reset; a store only lands on its access edge, which reset suppresses.
  always_ff @(posedge clk) begin
    if (access && we_q && !acc_err) begin
      mem[idx0] <= wdata_q[7:0];
      if (nbytes != 3'd1) mem[idx1] <= wdata_q[15:8];
      if (nbytes == 3'd4) begin
        mem[idx2] <= wdata_q[23:16];
        mem[idx3] <= wdata_q[31:24];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd  <= 32'd0;
      stat_wr  <= 32'd0;
      stat_err <= 32'd0;
    end else if (access) begin
      if (acc_err) begin
        if (stat_err != 32'hFFFF_FFFF) stat_err <= stat_err + 32'd1;
      end else if (we_q) begin
        if (stat_wr != 32'hFFFF_FFFF) stat_wr <= stat_wr + 32'd1;
      end else begin
        if (stat_rd != 32'hFFFF_FFFF) stat_rd <= stat_rd + 32'd1;
      end
    end
  end
`endif

endmodule
